vx_mem_req_arb: RTL and testbench

VX_MEM_REQ_ARB -- requirements
Module: VX_mem_req_arb

---
 rtl/vx_mem_req_arb_pkg.sv | 13 +
 rtl/vx_mem_req_arb_rr_arbiter.sv | 46 ++++
 rtl/vx_mem_req_arb.sv | 118 +++++++++++
 tb/tb_vx_mem_req_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_req_arb_pkg.sv
// Shared width helpers for the memory request arbiter: requester-select
// field width and the widened memory-side tag.
package vx_mem_req_arb_pkg;

  function automatic int sel_bits_f(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int out_tag_width_f(input int tag_width, input int num_reqs);
    return tag_width + sel_bits_f(num_reqs);
  endfunction

endpackage

// File: rtl/vx_mem_req_arb_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer past the winner whenever the grant is consumed.
module vx_mem_req_arb_rr_arbiter
  import vx_mem_req_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int SEL_BITS = sel_bits_f(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                adv_i,
  output logic [SEL_BITS-1:0] grant_idx_o,
  output logic                grant_valid_o
);

  logic [SEL_BITS-1:0] ptr_q;
  logic [SEL_BITS-1:0] ptr_d;
  int                  pos;

  // Scan requesters in priority order ptr, ptr+1, ... wrapping at NUM_REQS.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    pos           = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQS) pos = pos - NUM_REQS;
      if (!grant_valid_o && ((req_i & (NUM_REQS'(1) << pos)) != '0)) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = SEL_BITS'(pos);
      end
    end
  end

  assign ptr_d = (grant_idx_o == SEL_BITS'(NUM_REQS - 1)) ? '0 : grant_idx_o + SEL_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (adv_i && grant_valid_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_mem_req_arb.sv
// Shares one memory port among NUM_REQS requesters: registered round-robin
// request path, combinational tag-routed response path.
module vx_mem_req_arb
  import vx_mem_req_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8,
  localparam int SEL_BITS      = sel_bits_f(NUM_REQS),
  localparam int OUT_TAG_WIDTH = out_tag_width_f(TAG_WIDTH, NUM_REQS),
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [NUM_REQS-1:0]                    in_req_valid,
  output logic [NUM_REQS-1:0]                    in_req_ready,
  input  logic [NUM_REQS-1:0]                    in_req_rw,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]    in_req_addr,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    in_req_data,
  input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]  in_req_byteen,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     in_req_tag,

  output logic [NUM_REQS-1:0]                    in_rsp_valid,
  input  logic [NUM_REQS-1:0]                    in_rsp_ready,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]    in_rsp_data,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     in_rsp_tag,

  output logic                                   out_req_valid,
  input  logic                                   out_req_ready,
  output logic                                   out_req_rw,
  output logic [ADDR_WIDTH-1:0]                  out_req_addr,
  output logic [DATA_WIDTH-1:0]                  out_req_data,
  output logic [BYTEEN_WIDTH-1:0]                out_req_byteen,
  output logic [OUT_TAG_WIDTH-1:0]               out_req_tag,

  input  logic                                   out_rsp_valid,
  output logic                                   out_rsp_ready,
  input  logic [DATA_WIDTH-1:0]                  out_rsp_data,
  input  logic [OUT_TAG_WIDTH-1:0]               out_rsp_tag
);

  logic                     load_en;
  logic                     grant_valid;
  logic [SEL_BITS-1:0]      grant_idx;

  logic                     out_valid_q;
  logic                     out_valid_d;
  logic                     rw_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [BYTEEN_WIDTH-1:0]  byteen_q;
  logic [OUT_TAG_WIDTH-1:0] tag_q;

  logic [SEL_BITS-1:0]      rsp_idx;
  logic [NUM_REQS-1:0]      rsp_sel;

  // The output register may be refilled when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_req_ready;

  vx_mem_req_arb_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_arbiter (
    .clk           (clk),
    .reset         (reset),
    .req_i         (in_req_valid),
    .adv_i         (load_en),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign in_req_ready = (load_en && grant_valid) ? (NUM_REQS'(1) << grant_idx) : '0;
  assign out_valid_d  = load_en ? grant_valid : out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && grant_valid) begin
      rw_q     <= in_req_rw[grant_idx];
      addr_q   <= in_req_addr[grant_idx];
      data_q   <= in_req_data[grant_idx];
      byteen_q <= in_req_byteen[grant_idx];
      tag_q    <= {in_req_tag[grant_idx], grant_idx};
    end
  end

  assign out_req_valid  = out_valid_q;
  assign out_req_rw     = rw_q;
  assign out_req_addr   = addr_q;
  assign out_req_data   = data_q;
  assign out_req_byteen = byteen_q;
  assign out_req_tag    = tag_q;

  // An out-of-range index shifts the select bit off the top, routing nowhere.
  assign rsp_idx       = out_rsp_tag[SEL_BITS-1:0];
  assign rsp_sel       = NUM_REQS'(1) << rsp_idx;
  assign in_rsp_valid  = out_rsp_valid ? rsp_sel : '0;
  assign out_rsp_ready = |(in_rsp_ready & rsp_sel);
  assign in_rsp_tag    = {NUM_REQS{out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS]}};
  assign in_rsp_data   = {NUM_REQS{out_rsp_data}};

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && out_rsp_valid) begin
      assert (int'(rsp_idx) < NUM_REQS)
        else $error("vx_mem_req_arb: response index %0d out of range", rsp_idx);
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// Randomized and directed bench for vx_mem_req_arb against a behavioural
// round-robin model; also exercises a single-requester instance.
module tb_vx_mem_req_arb;
  localparam int N   = 4;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TW  = 8;
  localparam int OTW = TW + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]         in_req_valid, in_req_ready, in_req_rw;
  logic [N-1:0][AW-1:0] in_req_addr;
  logic [N-1:0][DW-1:0] in_req_data;
  logic [N-1:0][BW-1:0] in_req_byteen;
  logic [N-1:0][TW-1:0] in_req_tag;
  logic [N-1:0]         in_rsp_valid, in_rsp_ready;
  logic [N-1:0][DW-1:0] in_rsp_data;
  logic [N-1:0][TW-1:0] in_rsp_tag;
  logic                 out_req_valid, out_req_ready, out_req_rw;
  logic [AW-1:0]        out_req_addr;
  logic [DW-1:0]        out_req_data;
  logic [BW-1:0]        out_req_byteen;
  logic [OTW-1:0]       out_req_tag;
  logic                 out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]        out_rsp_data;
  logic [OTW-1:0]       out_rsp_tag;

  vx_mem_req_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready), .in_req_rw(in_req_rw),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_byteen(in_req_byteen),
    .in_req_tag(in_req_tag),
    .in_rsp_valid(in_rsp_valid), .in_rsp_ready(in_rsp_ready), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_rw(out_req_rw),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data), .out_req_byteen(out_req_byteen),
    .out_req_tag(out_req_tag),
    .out_rsp_valid(out_rsp_valid), .out_rsp_ready(out_rsp_ready), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag)
  );

  logic [0:0]         s_in_req_valid, s_in_req_ready, s_in_req_rw;
  logic [0:0][AW-1:0] s_in_req_addr;
  logic [0:0][DW-1:0] s_in_req_data;
  logic [0:0][BW-1:0] s_in_req_byteen;
  logic [0:0][TW-1:0] s_in_req_tag;
  logic [0:0]         s_in_rsp_valid, s_in_rsp_ready;
  logic [0:0][DW-1:0] s_in_rsp_data;
  logic [0:0][TW-1:0] s_in_rsp_tag;
  logic               s_out_req_valid, s_out_req_ready, s_out_req_rw;
  logic [AW-1:0]      s_out_req_addr;
  logic [DW-1:0]      s_out_req_data;
  logic [BW-1:0]      s_out_req_byteen;
  logic [TW:0]        s_out_req_tag;
  logic               s_out_rsp_valid, s_out_rsp_ready;
  logic [DW-1:0]      s_out_rsp_data;
  logic [TW:0]        s_out_rsp_tag;

  vx_mem_req_arb #(.NUM_REQS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut1 (
    .clk(clk), .reset(reset),
    .in_req_valid(s_in_req_valid), .in_req_ready(s_in_req_ready), .in_req_rw(s_in_req_rw),
    .in_req_addr(s_in_req_addr), .in_req_data(s_in_req_data), .in_req_byteen(s_in_req_byteen),
    .in_req_tag(s_in_req_tag),
    .in_rsp_valid(s_in_rsp_valid), .in_rsp_ready(s_in_rsp_ready), .in_rsp_data(s_in_rsp_data),
    .in_rsp_tag(s_in_rsp_tag),
    .out_req_valid(s_out_req_valid), .out_req_ready(s_out_req_ready), .out_req_rw(s_out_req_rw),
    .out_req_addr(s_out_req_addr), .out_req_data(s_out_req_data),
    .out_req_byteen(s_out_req_byteen), .out_req_tag(s_out_req_tag),
    .out_rsp_valid(s_out_rsp_valid), .out_rsp_ready(s_out_rsp_ready),
    .out_rsp_data(s_out_rsp_data), .out_rsp_tag(s_out_rsp_tag)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: the pending memory-side request and the fairness pointer.
  bit             m_valid;
  int             m_ptr;
  logic           m_rw;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [BW-1:0]  m_be;
  logic [OTW-1:0] m_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
  endtask

  // Drive one cycle of stimulus, compare every output against the model,
  // advance the model past the coming clock edge, then wait for the next negedge.
  task automatic cycle(input logic [N-1:0] v, input logic ordy, input logic rv,
                       input logic [OTW-1:0] rtag, input logic [N-1:0] rrdy,
                       input bit ftag, input logic [TW-1:0] tagv);
    bit            load, found;
    int            w, j, ridx;
    logic [DW-1:0] rdata;
    logic [N-1:0]  exp_rdy, exp_rv;
    in_req_valid  = v;
    out_req_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_req_rw[i]     = 1'($urandom);
      in_req_addr[i]   = AW'($urandom);
      in_req_data[i]   = DW'($urandom);
      in_req_byteen[i] = BW'($urandom);
      in_req_tag[i]    = ftag ? tagv : TW'($urandom);
    end
    rdata         = DW'($urandom);
    out_rsp_valid = rv;
    out_rsp_tag   = rtag;
    out_rsp_data  = rdata;
    in_rsp_ready  = rrdy;
    #1;
    load  = !m_valid || ordy;
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (!found && v[j]) begin
        found = 1'b1;
        w     = j;
      end
    end
    exp_rdy = (load && found) ? N'(1 << w) : '0;
    chk("in_req_ready", 64'(in_req_ready), 64'(exp_rdy));
    chk("out_req_valid", 64'(out_req_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_req_rw", 64'(out_req_rw), 64'(m_rw));
      chk("out_req_addr", 64'(out_req_addr), 64'(m_addr));
      chk("out_req_data", 64'(out_req_data), 64'(m_data));
      chk("out_req_byteen", 64'(out_req_byteen), 64'(m_be));
      chk("out_req_tag", 64'(out_req_tag), 64'(m_tag));
    end
    ridx   = int'(rtag[1:0]);
    exp_rv = rv ? N'(1 << ridx) : '0;
    chk("in_rsp_valid", 64'(in_rsp_valid), 64'(exp_rv));
    chk("out_rsp_ready", 64'(out_rsp_ready), 64'(rrdy[ridx]));
    chk("in_rsp_tag", 64'(in_rsp_tag[ridx]), 64'(rtag[OTW-1:2]));
    chk("in_rsp_data", 64'(in_rsp_data[ridx]), 64'(rdata));
    if (load) begin
      m_valid = found;
      if (found) begin
        m_rw   = in_req_rw[w];
        m_addr = in_req_addr[w];
        m_data = in_req_data[w];
        m_be   = in_req_byteen[w];
        m_tag  = {in_req_tag[w], 2'(w)};
        m_ptr  = (w + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in_req_valid = '0; in_req_rw = '0; in_req_addr = '0; in_req_data = '0;
    in_req_byteen = '0; in_req_tag = '0; in_rsp_ready = '0;
    out_req_ready = 1'b0; out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0;
    s_in_req_valid = '0; s_in_req_rw = '0; s_in_req_addr = '0; s_in_req_data = '0;
    s_in_req_byteen = '0; s_in_req_tag = '0; s_in_rsp_ready = '0;
    s_out_req_ready = 1'b0; s_out_rsp_valid = 1'b0; s_out_rsp_data = '0; s_out_rsp_tag = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 64'(out_req_valid), 64'(0));
    chk("reset_in_ready", 64'(in_req_ready), 64'(0));
    reset = 1'b0;

    // All requesters busy, memory always ready: strict rotation.
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 1'b1, 1'b0, '0, 4'h0, 1'b0, 8'h00);
      chk("rr_seq_valid", 64'(out_req_valid), 64'(1));
      chk("rr_seq_idx", 64'(out_req_tag[1:0]), 64'(k % 4));
    end

    // Lone requester 2 and tag-routed response.
    cycle(4'b0100, 1'b1, 1'b0, '0, 4'h0, 1'b1, 8'h5A);
    chk("tag_5a", 64'(out_req_tag), 64'(10'h16A));
    cycle(4'b0000, 1'b1, 1'b1, 10'h0CE, 4'hF, 1'b0, 8'h00);
    chk("rsp_valid_2", 64'(in_rsp_valid), 64'(4'b0100));
    chk("rsp_tag_2", 64'(in_rsp_tag[2]), 64'(8'h33));

    // Response backpressure from requester 1.
    cycle(4'b0000, 1'b1, 1'b1, 10'h005, 4'b1101, 1'b0, 8'h00);
    chk("rsp_bp_low", 64'(out_rsp_ready), 64'(0));
    cycle(4'b0000, 1'b1, 1'b1, 10'h005, 4'b0010, 1'b0, 8'h00);
    chk("rsp_bp_high", 64'(out_rsp_ready), 64'(1));

    // Memory stall with everyone requesting; pointer sits at 3 here.
    cycle(4'hF, 1'b1, 1'b0, '0, 4'h0, 1'b0, 8'h00);
    chk("pre_stall_idx", 64'(out_req_tag[1:0]), 64'(3));
    repeat (5) begin
      cycle(4'hF, 1'b0, 1'b0, '0, 4'h0, 1'b0, 8'h00);
      chk("stall_ready", 64'(in_req_ready), 64'(0));
      chk("stall_idx", 64'(out_req_tag[1:0]), 64'(3));
    end
    cycle(4'hF, 1'b1, 1'b0, '0, 4'h0, 1'b0, 8'h00);
    chk("release_idx", 64'(out_req_tag[1:0]), 64'(0));

    // Reset with an unaccepted request pending.
    cycle(4'hF, 1'b0, 1'b0, '0, 4'h0, 1'b0, 8'h00);
    chk("pending_valid", 64'(out_req_valid), 64'(1));
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_req_valid), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(4'b1010, 1'b1, 1'b0, '0, 4'h0, 1'b0, 8'h00);
    chk("post_reset_idx", 64'(out_req_tag[1:0]), 64'(1));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), OTW'($urandom),
            N'($urandom), 1'b0, 8'h00);
    end

    // Single-requester instance.
    s_in_req_valid  = 1'b1;
    s_in_req_tag[0] = 8'hFF;
    s_out_req_ready = 1'b1;
    #1;
    chk("n1_in_ready", 64'(s_in_req_ready), 64'(1));
    @(negedge clk);
    s_in_req_valid = 1'b0;
    #1;
    chk("n1_out_valid", 64'(s_out_req_valid), 64'(1));
    chk("n1_out_tag", 64'(s_out_req_tag), 64'(9'h1FE));
    s_out_rsp_valid = 1'b1;
    s_out_rsp_tag   = 9'h1FE;
    s_out_rsp_data  = 32'hDEAD_BEEF;
    s_in_rsp_ready  = 1'b1;
    #1;
    chk("n1_rsp_valid", 64'(s_in_rsp_valid), 64'(1));
    chk("n1_rsp_tag", 64'(s_in_rsp_tag[0]), 64'(8'hFF));
    chk("n1_rsp_data", 64'(s_in_rsp_data[0]), 64'(32'hDEAD_BEEF));
    chk("n1_rsp_ready", 64'(s_out_rsp_ready), 64'(1));
    s_out_rsp_valid = 1'b0;
    @(negedge clk);
    chk("n1_drain", 64'(s_out_req_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
